// File: rtl/nor_gate_array.sv
// nor_gate_array: independent multi-input NOR gates, each with a per-channel
// propagation delay. Transport mode shifts every sample through; inertial mode
// only passes a level that persists for DELAY_CYCLES edges and flags pulses
// it swallows.
module nor_gate_array #(
    parameter int unsigned         CHANNELS     = 2,
    parameter int unsigned         INPUTS       = 4,
    parameter int unsigned         DELAY_CYCLES = 1,
    parameter logic [CHANNELS-1:0] IC           = '0,
    parameter bit                  INERTIAL     = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS*INPUTS-1:0] in,
    output logic [CHANNELS-1:0]        y,
    output logic [CHANNELS-1:0]        settled,
    output logic [CHANNELS-1:0]        glitch,
    input  logic                       vcc,
    input  logic                       gnd
);

    localparam int unsigned CntW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    // Power pins exist only so netlists that wire them still connect.
    logic unused_pwr;
    assign unused_pwr = vcc ^ gnd;

    logic [CHANNELS-1:0] n;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign n[c] = ~|in[c*INPUTS +: INPUTS];

        if (INERTIAL) begin : g_inertial
            logic            y_q;
            logic            y_d;
            logic            glitch_q;
            logic            glitch_d;
            logic [CntW-1:0] cnt_q;
            logic [CntW-1:0] cnt_d;

            // Count consecutive edges where the gate disagrees with the output;
            // commit after DELAY_CYCLES of them, report a pulse if it falls back early.
            always_comb begin
                y_d      = y_q;
                cnt_d    = cnt_q;
                glitch_d = 1'b0;
                if (n[c] == y_q) begin
                    cnt_d    = '0;
                    glitch_d = (cnt_q != '0);
                end else if (cnt_q == CntW'(DELAY_CYCLES - 1)) begin
                    y_d   = n[c];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            // Output, counter and glitch pulse registers with async reset to IC.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q      <= IC[c];
                    cnt_q    <= '0;
                    glitch_q <= 1'b0;
                end else begin
                    y_q      <= y_d;
                    cnt_q    <= cnt_d;
                    glitch_q <= glitch_d;
                end
            end

            assign y[c]       = y_q;
            assign settled[c] = (cnt_q == '0);
            assign glitch[c]  = glitch_q;
        end else begin : g_transport
            logic [DELAY_CYCLES-1:0] sr_q;
            logic [DELAY_CYCLES-1:0] sr_d;

            // Stage 0 takes the fresh NOR sample, every other stage takes its predecessor.
            always_comb begin
                sr_d    = sr_q;
                sr_d[0] = n[c];
                for (int i = 1; i < int'(DELAY_CYCLES); i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            // Delay line with every stage forced to the initial condition on reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q <= {DELAY_CYCLES{IC[c]}};
                end else begin
                    sr_q <= sr_d;
                end
            end

            // Last stage is the output; settled when nothing different is in flight.
            assign y[c]       = sr_q[DELAY_CYCLES-1];
            assign settled[c] = (sr_q == {DELAY_CYCLES{sr_q[DELAY_CYCLES-1]}});
            assign glitch[c]  = 1'b0;
        end
    end

endmodule

// File: tb/tb_nor_gate_array.sv
// Self-checking bench for nor_gate_array: directed delay/pulse/reset scenarios
// on small instances plus long random runs of 16-channel instances against a
// history-based reference model.
module tb_nor_gate_array;

    localparam logic [1:0]  IC_A  = 2'b10;
    localparam logic [1:0]  IC_B  = 2'b11;
    localparam logic [1:0]  IC_C  = 2'b11;
    localparam logic [15:0] IC_RT = 16'hA5C3;
    localparam logic [15:0] IC_RI = 16'h3C5A;
    localparam int          D_RT  = 3;
    localparam int          D_RI  = 5;

    logic clk, rst, vcc, gnd;
    logic [7:0]   in_a, in_b, in_c;
    logic [1:0]   y_a, st_a, gl_a, y_b, st_b, gl_b, y_c, st_c, gl_c;
    logic [127:0] in_r;
    logic [15:0]  y_rt, st_rt, gl_rt, y_ri, st_ri, gl_ri;

    int checks   = 0;
    int failures = 0;

    logic [15:0] nh[$];

    nor_gate_array #(.CHANNELS(2), .INPUTS(4), .DELAY_CYCLES(1), .IC(IC_A), .INERTIAL(1'b0)) u_d1 (
        .clk(clk), .rst(rst), .in(in_a), .y(y_a), .settled(st_a), .glitch(gl_a),
        .vcc(vcc), .gnd(gnd));

    nor_gate_array #(.CHANNELS(2), .INPUTS(4), .DELAY_CYCLES(3), .IC(IC_B), .INERTIAL(1'b0)) u_tr3 (
        .clk(clk), .rst(rst), .in(in_b), .y(y_b), .settled(st_b), .glitch(gl_b),
        .vcc(vcc), .gnd(gnd));

    nor_gate_array #(.CHANNELS(2), .INPUTS(4), .DELAY_CYCLES(4), .IC(IC_C), .INERTIAL(1'b1)) u_in4 (
        .clk(clk), .rst(rst), .in(in_c), .y(y_c), .settled(st_c), .glitch(gl_c),
        .vcc(vcc), .gnd(gnd));

    nor_gate_array #(.CHANNELS(16), .INPUTS(8), .DELAY_CYCLES(D_RT), .IC(IC_RT),
                     .INERTIAL(1'b0)) u_rt (
        .clk(clk), .rst(rst), .in(in_r), .y(y_rt), .settled(st_rt), .glitch(gl_rt),
        .vcc(vcc), .gnd(gnd));

    nor_gate_array #(.CHANNELS(16), .INPUTS(8), .DELAY_CYCLES(D_RI), .IC(IC_RI),
                     .INERTIAL(1'b1)) u_ri (
        .clk(clk), .rst(rst), .in(in_r), .y(y_ri), .settled(st_ri), .glitch(gl_ri),
        .vcc(vcc), .gnd(gnd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        in_a = '0;
        in_b = '0;
        in_c = '0;
        in_r = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // NOR sample of transport-model channel c at edge j (1-based); before edge 1 it is IC.
    function automatic logic hist_bit(input int j, input int c);
        logic [15:0] v;
        v = IC_RT;
        if (j >= 1) v = nh[j-1];
        return v[c];
    endfunction

    task automatic test_reset();
        #12;
        checks++; if (y_a !== 2'b10) begin failures++; $display("FAIL reset_y_a got=%b exp=%b", y_a, 2'b10); end
        checks++; if (st_a !== 2'b11) begin failures++; $display("FAIL reset_settled_a got=%b exp=%b", st_a, 2'b11); end
        checks++; if (gl_a !== 2'b00) begin failures++; $display("FAIL reset_glitch_a got=%b exp=%b", gl_a, 2'b00); end
        checks++; if (y_b !== IC_B) begin failures++; $display("FAIL reset_y_b got=%b exp=%b", y_b, IC_B); end
        checks++; if (y_c !== IC_C || st_c !== 2'b11 || gl_c !== 2'b00) begin
            failures++; $display("FAIL reset_c got y=%b s=%b g=%b exp y=%b s=11 g=00", y_c, st_c, gl_c, IC_C); end
        checks++; if (y_rt !== IC_RT || st_rt !== 16'hFFFF) begin
            failures++; $display("FAIL reset_rt got y=%h s=%h exp y=%h s=ffff", y_rt, st_rt, IC_RT); end
        checks++; if (y_ri !== IC_RI || st_ri !== 16'hFFFF || gl_ri !== 16'h0) begin
            failures++; $display("FAIL reset_ri got y=%h s=%h g=%h exp y=%h s=ffff g=0", y_ri, st_ri, gl_ri, IC_RI); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_delay1();
        logic [1:0] exp_y;
        do_reset();
        checks++; if (y_a !== IC_A) begin failures++; $display("FAIL d1_after_reset got=%b exp=%b", y_a, IC_A); end
        for (int e = 1; e <= 12; e++) begin
            for (int c = 0; c < 2; c++) begin
                in_a[c*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
                exp_y[c] = (in_a[c*4 +: 4] == 4'h0);
            end
            @(posedge clk); #1;
            checks++; if (y_a !== exp_y) begin failures++; $display("FAIL d1_y e=%0d got=%b exp=%b", e, y_a, exp_y); end
            checks++; if (st_a !== 2'b11 || gl_a !== 2'b00) begin
                failures++; $display("FAIL d1_flags e=%0d got s=%b g=%b exp s=11 g=00", e, st_a, gl_a); end
        end
    endtask

    task automatic test_transport_step();
        logic exp_y, exp_s;
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            exp_y = (e >= 7) ? 1'b0 : 1'b1;
            exp_s = (e == 5 || e == 6) ? 1'b0 : 1'b1;
            checks++; if (y_b[0] !== exp_y) begin failures++; $display("FAIL tstep_y e=%0d got=%b exp=%b", e, y_b[0], exp_y); end
            checks++; if (st_b[0] !== exp_s) begin failures++; $display("FAIL tstep_settled e=%0d got=%b exp=%b", e, st_b[0], exp_s); end
            checks++; if (gl_b !== 2'b00 || y_b[1] !== 1'b1) begin
                failures++; $display("FAIL tstep_other e=%0d got g=%b y1=%b exp g=00 y1=1", e, gl_b, y_b[1]); end
            if (e == 4) in_b = 8'h04;
        end
    endtask

    task automatic test_transport_pulse();
        logic exp_y, exp_s;
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            exp_y = (e == 5) ? 1'b0 : 1'b1;
            exp_s = (e >= 3 && e <= 5) ? 1'b0 : 1'b1;
            checks++; if (y_b[0] !== exp_y) begin failures++; $display("FAIL tpulse_y e=%0d got=%b exp=%b", e, y_b[0], exp_y); end
            checks++; if (st_b[0] !== exp_s) begin failures++; $display("FAIL tpulse_settled e=%0d got=%b exp=%b", e, st_b[0], exp_s); end
            checks++; if (gl_b !== 2'b00) begin failures++; $display("FAIL tpulse_glitch e=%0d got=%b exp=00", e, gl_b); end
            if (e == 2) in_b = 8'h04;
            if (e == 3) in_b = 8'h00;
        end
    endtask

    // Pulse of width w (n low at edges 3..2+w) into the D=4 inertial instance.
    task automatic test_inertial_pulse(input int w);
        logic exp_y, exp_s, exp_g;
        int last;
        do_reset();
        last = (w >= 4) ? 12 : 8;
        for (int e = 1; e <= last; e++) begin
            @(posedge clk); #1;
            if (w >= 4) begin
                exp_y = (e >= 6 && e <= 9) ? 1'b0 : 1'b1;
                exp_s = !((e >= 3 && e <= 5) || (e >= 7 && e <= 9));
                exp_g = 1'b0;
            end else begin
                exp_y = 1'b1;
                exp_s = !(e >= 3 && e <= 2 + w);
                exp_g = (e == 3 + w);
            end
            checks++; if (y_c[0] !== exp_y) begin failures++; $display("FAIL inert_w%0d_y e=%0d got=%b exp=%b", w, e, y_c[0], exp_y); end
            checks++; if (st_c[0] !== exp_s) begin failures++; $display("FAIL inert_w%0d_settled e=%0d got=%b exp=%b", w, e, st_c[0], exp_s); end
            checks++; if (gl_c[0] !== exp_g) begin failures++; $display("FAIL inert_w%0d_glitch e=%0d got=%b exp=%b", w, e, gl_c[0], exp_g); end
            checks++; if (y_c[1] !== 1'b1 || gl_c[1] !== 1'b0) begin
                failures++; $display("FAIL inert_w%0d_ch1 e=%0d got y=%b g=%b exp y=1 g=0", w, e, y_c[1], gl_c[1]); end
            if (e == 2) in_c = 8'h04;
            if (e == 2 + w) in_c = 8'h00;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            if (e == 2) in_c = 8'h04;
            if (e == 6) in_c = 8'h00;
        end
        checks++; if (y_c[0] !== 1'b0 || st_c[0] !== 1'b0) begin
            failures++; $display("FAIL arst_pre got y=%b s=%b exp y=0 s=0", y_c[0], st_c[0]); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (y_c !== IC_C) begin failures++; $display("FAIL arst_y got=%b exp=%b", y_c, IC_C); end
        checks++; if (st_c !== 2'b11 || gl_c !== 2'b00) begin
            failures++; $display("FAIL arst_flags got s=%b g=%b exp s=11 g=00", st_c, gl_c); end
        @(posedge clk); #1;
        checks++; if (y_c !== IC_C) begin failures++; $display("FAIL arst_hold got=%b exp=%b", y_c, IC_C); end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            checks++; if (y_c[0] !== 1'b1 || st_c[0] !== 1'b1 || gl_c[0] !== 1'b0) begin
                failures++; $display("FAIL arst_resume e=%0d got y=%b s=%b g=%b exp y=1 s=1 g=0", e, y_c[0], st_c[0], gl_c[0]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] tgt, n_now, ym, gm, exp_yt, exp_st, exp_si;
        int run[16];
        int k;
        do_reset();
        tgt = '1;
        ym  = IC_RI;
        for (int c = 0; c < 16; c++) run[c] = 0;
        nh.delete();
        k = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk); #1;
            for (int c = 0; c < 16; c++) n_now[c] = (in_r[c*8 +: 8] == 8'h00);
            nh.push_back(n_now);
            k++;
            // Transport: output is the sample from D-1 edges ago; settled if the window agrees.
            for (int c = 0; c < 16; c++) begin
                exp_yt[c] = hist_bit(k - D_RT + 1, c);
                exp_st[c] = 1'b1;
                for (int j = k - D_RT + 1; j <= k; j++) begin
                    if (hist_bit(j, c) != exp_yt[c]) exp_st[c] = 1'b0;
                end
            end
            // Inertial: a level change must persist D consecutive edges to pass.
            gm = '0;
            for (int c = 0; c < 16; c++) begin
                if (n_now[c] != ym[c]) begin
                    run[c]++;
                    if (run[c] == D_RI) begin
                        ym[c]  = n_now[c];
                        run[c] = 0;
                    end
                end else begin
                    gm[c]  = (run[c] != 0);
                    run[c] = 0;
                end
                exp_si[c] = (run[c] == 0);
            end
            checks++; if (y_rt !== exp_yt) begin failures++; $display("FAIL rnd_tr_y cyc=%0d got=%h exp=%h", cyc, y_rt, exp_yt); end
            checks++; if (st_rt !== exp_st) begin failures++; $display("FAIL rnd_tr_settled cyc=%0d got=%h exp=%h", cyc, st_rt, exp_st); end
            checks++; if (gl_rt !== 16'h0) begin failures++; $display("FAIL rnd_tr_glitch cyc=%0d got=%h exp=0000", cyc, gl_rt); end
            checks++; if (y_ri !== ym) begin failures++; $display("FAIL rnd_in_y cyc=%0d got=%h exp=%h", cyc, y_ri, ym); end
            checks++; if (st_ri !== exp_si) begin failures++; $display("FAIL rnd_in_settled cyc=%0d got=%h exp=%h", cyc, st_ri, exp_si); end
            checks++; if (gl_ri !== gm) begin failures++; $display("FAIL rnd_in_glitch cyc=%0d got=%h exp=%h", cyc, gl_ri, gm); end
            if (cyc == 5000) begin
                rst = 1'b1;
                #1;
                checks++; if (y_rt !== IC_RT || st_rt !== 16'hFFFF) begin
                    failures++; $display("FAIL rnd_arst_tr got y=%h s=%h exp y=%h s=ffff", y_rt, st_rt, IC_RT); end
                checks++; if (y_ri !== IC_RI || st_ri !== 16'hFFFF || gl_ri !== 16'h0) begin
                    failures++; $display("FAIL rnd_arst_in got y=%h s=%h g=%h exp y=%h s=ffff g=0", y_ri, st_ri, gl_ri, IC_RI); end
                #1;
                rst = 1'b0;
                nh.delete();
                k  = 0;
                ym = IC_RI;
                for (int c = 0; c < 16; c++) run[c] = 0;
            end
            for (int c = 0; c < 16; c++) begin
                if ($urandom_range(0, 99) < 30) tgt[c] = ~tgt[c];
                in_r[c*8 +: 8] = tgt[c] ? 8'h00 : 8'($urandom_range(1, 255));
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        vcc  = 1'b1;
        gnd  = 1'b0;
        in_a = '0;
        in_b = '0;
        in_c = '0;
        in_r = '0;
        test_reset();
        test_delay1();
        test_transport_step();
        test_transport_pulse();
        test_inertial_pulse(2);
        test_inertial_pulse(3);
        test_inertial_pulse(4);
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
